// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath width, NOP encoding and fetch FSM states.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register with bubble/load/hold controls; bubble wins over load.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bubble,
    input  logic            load,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc4_in,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc4_out,
    output logic            valid_out
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc4_q,   pc4_d;
    logic            valid_q, valid_d;

    // Next-state selection: bubble, load, or hold.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble) begin
            instr_d = NOP_INSTR;
            pc4_d   = {XLEN{1'b0}};
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end else begin
            instr_d = instr_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end
    end

    // Register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= {XLEN{1'b0}};
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_out = instr_q;
    assign pc4_out   = pc4_q;
    assign valid_out = valid_q;

endmodule

// File: rtl/ifid_fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, stall hold buffer, flush/drain, IF/ID load.
module ifid_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_write,
    input  logic            ifid_write,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ifid_instr,
    output logic [XLEN-1:0] ifid_pc4,
    output logic            ifid_valid
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc4_q, hold_pc4_d;

    logic            stall_s;
    logic            ack_s;
    logic [XLEN-1:0] pc_plus4_s;
    logic [XLEN-1:0] redir_s;
    logic            ifid_bubble_s;
    logic            ifid_load_s;
    logic [XLEN-1:0] ifid_instr_in_s;
    logic [XLEN-1:0] ifid_pc4_in_s;

    assign stall_s    = !pc_write || !ifid_write;
    assign ack_s      = imem_ack && req_q;
    assign pc_plus4_s = pc_q + 32'd4;
    assign redir_s    = word_align(redirect_pc);

    // Fetch FSM next-state, address/PC update and IF/ID control.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        addr_d          = addr_q;
        req_d           = req_q;
        hold_instr_d    = hold_instr_q;
        hold_pc4_d      = hold_pc4_q;
        ifid_bubble_s   = 1'b0;
        ifid_load_s     = 1'b0;
        ifid_instr_in_s = imem_rdata;
        ifid_pc4_in_s   = pc_plus4_s;

        case (state_q)
            FS_IDLE: begin
                state_d = FS_FETCH;
                req_d   = 1'b1;
                if (flush) begin
                    ifid_bubble_s = 1'b1;
                    pc_d          = redir_s;
                    addr_d        = redir_s;
                end else begin
                    addr_d = pc_q;
                end
            end
            FS_FETCH: begin
                if (flush) begin
                    ifid_bubble_s = 1'b1;
                    pc_d          = redir_s;
                    if (ack_s) begin
                        addr_d = redir_s;
                    end else begin
                        // Stale request must complete at its original address.
                        state_d = FS_DRAIN;
                    end
                end else if (ack_s) begin
                    pc_d   = pc_plus4_s;
                    addr_d = pc_plus4_s;
                    if (!stall_s) begin
                        ifid_load_s = 1'b1;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = pc_plus4_s;
                        req_d        = 1'b0;
                        state_d      = FS_HOLD;
                    end
                end else if (!stall_s) begin
                    ifid_bubble_s = 1'b1;
                end else begin
                    ifid_bubble_s = 1'b0;
                end
            end
            FS_HOLD: begin
                if (flush) begin
                    ifid_bubble_s = 1'b1;
                    pc_d          = redir_s;
                    addr_d        = redir_s;
                    req_d         = 1'b1;
                    state_d       = FS_FETCH;
                end else if (!stall_s) begin
                    ifid_load_s     = 1'b1;
                    ifid_instr_in_s = hold_instr_q;
                    ifid_pc4_in_s   = hold_pc4_q;
                    addr_d          = pc_q;
                    req_d           = 1'b1;
                    state_d         = FS_FETCH;
                end else begin
                    state_d = FS_HOLD;
                end
            end
            FS_DRAIN: begin
                if (flush) begin
                    ifid_bubble_s = 1'b1;
                    pc_d          = redir_s;
                end else begin
                    ifid_bubble_s = !stall_s;
                end
                if (ack_s) begin
                    state_d = FS_FETCH;
                    addr_d  = flush ? redir_s : pc_q;
                end else begin
                    state_d = FS_DRAIN;
                end
            end
            default: begin
                state_d = FS_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            hold_instr_q <= {XLEN{1'b0}};
            hold_pc4_q   <= {XLEN{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
        end
    end

    ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .bubble    (ifid_bubble_s),
        .load      (ifid_load_s),
        .instr_in  (ifid_instr_in_s),
        .pc4_in    (ifid_pc4_in_s),
        .instr_out (ifid_instr),
        .pc4_out   (ifid_pc4),
        .valid_out (ifid_valid)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

endmodule

// File: tb/tb_ifid_fetch_stage.sv
// Scoreboard bench for ifid_fetch_stage: directed cycles push expected post-edge state, a monitor compares.
module tb_ifid_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        ifid_write;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;

    typedef struct {
        string       tag;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ifid_fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ifid_instr  (ifid_instr),
        .ifid_pc4    (ifid_pc4),
        .ifid_valid  (ifid_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic push_exp(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_v, input logic [31:0] e_i, input logic [31:0] e_p4);
        exp_t e;
        e.tag = tag; e.req = e_req; e.addr = e_addr; e.valid = e_v; e.instr = e_i; e.pc4 = e_p4;
        sb_q.push_back(e);
    endtask

    // One clock of stimulus followed by the expected state after that edge.
    task automatic cyc(input string tag, input logic pw, input logic iw, input logic fl,
                       input logic [31:0] rpc, input logic ack, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_addr, input logic e_v,
                       input logic [31:0] e_i, input logic [31:0] e_p4);
        pc_write = pw; ifid_write = iw; flush = fl; redirect_pc = rpc;
        imem_ack = ack; imem_rdata = rd;
        @(posedge clk); #1;
        push_exp(tag, e_req, e_addr, e_v, e_i, e_p4);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                n_cmp++;
                if ({imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4} !==
                    {e.req, e.addr, e.valid, e.instr, e.pc4}) begin
                    n_bad++;
                    $display("FAIL %s: got req=%0b addr=%h v=%0b instr=%h pc4=%h, want req=%0b addr=%h v=%0b instr=%h pc4=%h",
                             e.tag, imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc4,
                             e.req, e.addr, e.valid, e.instr, e.pc4);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; pc_write = 1'b1; ifid_write = 1'b1; flush = 1'b0;
        redirect_pc = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;
        @(posedge clk); #1;
        push_exp("reset_state", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Zero-wait memory.
        cyc("first_req",  1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,           1'b1, 32'h0,  1'b0, 32'h0,           32'h0);
        cyc("zw_0",       1'b1, 1'b1, 1'b0, 32'h0, 1'b1, mem_word(32'h0), 1'b1, 32'h4,  1'b1, mem_word(32'h0), 32'h4);
        cyc("zw_4",       1'b1, 1'b1, 1'b0, 32'h0, 1'b1, mem_word(32'h4), 1'b1, 32'h8,  1'b1, mem_word(32'h4), 32'h8);
        // Stall coincident with ack at address 8.
        cyc("stall_ack",  1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8C09_0004,   1'b0, 32'hC,  1'b1, mem_word(32'h4), 32'h8);
        cyc("stall_hold", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,           1'b0, 32'hC,  1'b1, mem_word(32'h4), 32'h8);
        cyc("hold_rel",   1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,           1'b1, 32'hC,  1'b1, 32'h8C09_0004,   32'hC);
        // Three-cycle latency.
        cyc("lat_bub1",   1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,           1'b1, 32'hC,  1'b0, 32'h0,           32'h0);
        cyc("lat_bub2",   1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,           1'b1, 32'hC,  1'b0, 32'h0,           32'h0);
        cyc("lat_ack",    1'b1, 1'b1, 1'b0, 32'h0, 1'b1, mem_word(32'hC), 1'b1, 32'h10, 1'b1, mem_word(32'hC), 32'h10);
        // Flush while 0x10 outstanding; redirect low bits ignored.
        cyc("drain_ent",  1'b1, 1'b1, 1'b1, 32'h43, 1'b0, 32'h0,           1'b1, 32'h10, 1'b0, 32'h0,           32'h0);
        cyc("drain_wait", 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,           1'b1, 32'h10, 1'b0, 32'h0,           32'h0);
        cyc("drain_ack",  1'b1, 1'b1, 1'b0, 32'h0,  1'b1, mem_word(32'h10),1'b1, 32'h40, 1'b0, 32'h0,           32'h0);
        cyc("redir_40",   1'b1, 1'b1, 1'b0, 32'h0,  1'b1, mem_word(32'h40),1'b1, 32'h44, 1'b1, mem_word(32'h40),32'h44);
        // Flush with stall and ack together; target at top of address space.
        cyc("flush_stall",1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, mem_word(32'h44), 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
        cyc("wrap",       1'b1, 1'b1, 1'b0, 32'h0, 1'b1, mem_word(32'hFFFF_FFFC), 1'b1, 32'h0, 1'b1, mem_word(32'hFFFF_FFFC), 32'h0);
        cyc("after_wrap", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, mem_word(32'h0), 1'b1, 32'h4,  1'b1, mem_word(32'h0), 32'h4);
        // Repeated flush during drain retargets.
        cyc("drain2_ent", 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,         1'b1, 32'h4,  1'b0, 32'h0,           32'h0);
        cyc("drain2_re",  1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,         1'b1, 32'h4,  1'b0, 32'h0,           32'h0);
        cyc("drain2_ack", 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, mem_word(32'h4),1'b1, 32'h200,1'b0, 32'h0,          32'h0);
        cyc("redir_200",  1'b1, 1'b1, 1'b0, 32'h0,   1'b1, mem_word(32'h200),1'b1,32'h204,1'b1,mem_word(32'h200),32'h204);
        cyc("pre_rst",    1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h204,1'b0, 32'h0,           32'h0);

        // Asynchronous reset mid-request, then an ack while in reset.
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        push_exp("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        push_exp("rst_ack_ign", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ifid_fetch_stage.md
# ifid_fetch_stage

Instruction-fetch stage for the 5-stage MIPS pipeline: owns the PC register, issues instruction-memory requests over a req/ack handshake, and loads the IF/ID pipeline register. It consumes the stall controls the load-use hazard unit produces (`pc_write`, `ifid_write`) and the branch/jump flush from ID. It absorbs variable-latency instruction memory by inserting bubbles and holding returned instructions while the pipeline is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset.
- `NOP_INSTR`, 32'h0000_0000, encoding loaded into IF/ID on flush or bubble (`sll $0,$0,0`).
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. One clock; reset asynchronous and active-low.
- `pc_write`  in  1  0 = hold PC (load-use stall).
- `ifid_write`  in  1  0 = hold IF/ID contents (load-use stall).
- `flush`  in  1  branch taken or jump resolved in ID; redirect fetch.
- `redirect_pc`  in  32  target PC, valid when `flush`=1.
- `imem_req`  out  1  request valid; registered.
- `imem_addr`  out  32  word-aligned fetch address; stable while `imem_req`=1 until ack.
- `imem_ack`  in  1  memory returns data this cycle; sampled only when `imem_req`=1.
- `imem_rdata`  in  32  instruction, valid with `imem_ack`.
- `ifid_instr`  out  32  IF/ID instruction.
- `ifid_pc4`  out  32  IF/ID PC+4.
- `ifid_valid`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Stall condition `stall = !pc_write || !ifid_write`; both signals are treated as one hold request.
- States: IDLE (post-reset), FETCH (request outstanding), HOLD (instruction captured, pipeline stalled, no request), DRAIN (redirect pending while stale request outstanding).
- IDLE -> FETCH on first edge after reset release; `imem_req` rises then, `imem_addr`=`RESET_PC`.
- FETCH, ack, !stall, !flush: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; remain FETCH with new address next cycle.
- FETCH, ack, stall, !flush: rdata and pc+4 into hold buffer; pc <= pc+4; -> HOLD; `imem_req` drops.
- FETCH, no ack, !stall: IF/ID <= {NOP_INSTR, 0, valid=0} (bubble). With stall: IF/ID holds.
- HOLD, !stall: IF/ID <= hold buffer, valid=1; -> FETCH at current pc.
- HOLD, stall: hold everything.
- Flush (priority over stall and ack), any state: IF/ID <= {NOP_INSTR, 0, 0}; pc <= `redirect_pc`.
  - If a request is outstanding and not acked this cycle: -> DRAIN; keep `imem_req`/`imem_addr` at the stale address until ack; discard that data; then -> FETCH at `redirect_pc`.
  - If acked this cycle, or state HOLD/IDLE: discard data/buffer; -> FETCH at `redirect_pc` next cycle.
- Flush during DRAIN: update pending target only; stay DRAIN.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. `redirect_pc[1:0]` ignored (forced 0).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `ifid_instr`=`NOP_INSTR`, `ifid_pc4`=0, `ifid_valid`=0; state IDLE; hold buffer cleared.
- Reset assertion mid-transaction aborts immediately; any later ack is ignored (`imem_req`=0).
- Zero-wait memory (`imem_ack` high whenever requested): one instruction per cycle; first valid IF/ID two edges after reset release.
- N-cycle memory latency: N-1 bubbles per instruction.
- Flush-to-first-redirected-instruction in IF/ID: 2 edges with zero-wait memory and no drain.

## Structure
- Shared `cpu_pkg`: XLEN=32, `NOP_INSTR` default, fetch-state enum {IDLE, FETCH, HOLD, DRAIN}.
- Sub-module `ifid_reg`: IF/ID register with load/hold/bubble controls, reused by the ID/EX equivalents.

## Test plan
- Reset release, ack tied 1 -> `imem_addr` 0,4,8,…; `ifid_valid`=1 from 2nd edge; `ifid_pc4`=4,8,12.
- 3-cycle ack latency -> two bubbles (`ifid_valid`=0, `ifid_instr`=0) between each valid instruction.
- `ifid_write`=`pc_write`=0 for 2 cycles coincident with ack of 0x8C090004 at addr 8 -> IF/ID holds prior instr, req drops; on release IF/ID=0x8C090004, pc4=12, next addr 12.
- `flush`, `redirect_pc`=0x40 while addr 0x10 outstanding -> addr stays 0x10 until ack, data discarded, next req addr 0x40, no valid instr from 0x10.
- `flush` and `stall` together -> IF/ID becomes NOP/valid 0, pc=redirect.
- Fetch at 0xFFFF_FFFC -> `ifid_pc4`=0, next addr 0; `rst_n` low mid-request -> `imem_req`=0 and outputs at reset values immediately.
